// File: rtl/fir_tap_mac.sv
// fir_tap_mac
//
// Multiply-accumulate consumer for the FIR circular sample buffer, running in the
// 64x sample-replay clock domain. Each replayed window arrives as a burst of
// NTAP = 2**AWIDTH beats with tap 0 marked by dfirst. For each tap the block reads
// the matching coefficient from a synchronous ROM and accumulates the products.
// It emits one rounded (half up), saturated result per complete burst. A burst cut
// short by an early dfirst is dropped and reported on err_short.
//
// Ports:
//   clk         sample-replay clock
//   rst         synchronous, active-high reset; flushes the FSM and the pipeline
//   din         sample beat, signed Q1.(DWIDTH-1)
//   dvalid      din is valid this cycle; gaps are allowed anywhere in a burst
//   dfirst      with dvalid: the beat is tap 0
//   coef_addr   coefficient ROM address (combinational)
//   coef_data   coefficient ROM data, signed Q1.(CWIDTH-1), one cycle after coef_addr
//   dout        filter result, signed Q1.(DWIDTH-1); holds until the next result
//   dout_valid  one-cycle pulse, three cycles after the last tap beat
//   busy        a burst is being accepted or still travelling through the pipeline
//   err_short   one-cycle pulse, the cycle after a burst is aborted by an early dfirst

module fir_tap_mac #(
    parameter int unsigned DWIDTH   = 16,
    parameter int unsigned CWIDTH   = 16,
    parameter int unsigned AWIDTH   = 6,
    parameter int unsigned ACCWIDTH = DWIDTH + CWIDTH + AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] din,
    input  logic              dvalid,
    input  logic              dfirst,
    output logic [AWIDTH-1:0] coef_addr,
    input  logic [CWIDTH-1:0] coef_data,
    output logic [DWIDTH-1:0] dout,
    output logic              dout_valid,
    output logic              busy,
    output logic              err_short
);

    localparam int unsigned ProdWidth = DWIDTH + CWIDTH;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // ------------------------------------------------------------------
    // Burst framing
    // ------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [AWIDTH-1:0] tap_cnt_q, tap_cnt_d;

    logic beat_first;
    logic beat_accept;
    logic beat_abort;
    logic beat_last;

    always_comb begin
        beat_first  = dvalid && dfirst;
        beat_accept = beat_first || (dvalid && (state_q == StRun));
        // In StRun tap_cnt_q is never 0, so any dfirst there cuts a burst short.
        beat_abort  = beat_first && (state_q == StRun);
        beat_last   = dvalid && !dfirst && (state_q == StRun) && (&tap_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            tap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_cnt_q <= tap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tap_cnt_d = tap_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (beat_first) begin
                    state_d   = StRun;
                    tap_cnt_d = AWIDTH'(1);
                end
            end
            StRun: begin
                if (beat_first) begin
                    // Restart: this beat is tap 0 of a fresh burst.
                    tap_cnt_d = AWIDTH'(1);
                end else if (dvalid) begin
                    if (&tap_cnt_q) begin
                        state_d   = StIdle;
                        tap_cnt_d = '0;
                    end else begin
                        tap_cnt_d = tap_cnt_q + AWIDTH'(1);
                    end
                end
            end
            default: begin
                state_d   = StIdle;
                tap_cnt_d = '0;
            end
        endcase
    end

    // Tap 0 must address coefficient 0 before tap_cnt_q has been reloaded.
    assign coef_addr = beat_first ? '0 : tap_cnt_q;

    // ------------------------------------------------------------------
    // S1: capture the beat and its flags; coef_data arrives alongside
    // ------------------------------------------------------------------
    logic              s1_valid_q;
    logic              s1_first_q;
    logic              s1_last_q;
    logic              s1_abort_q;
    logic [DWIDTH-1:0] s1_din_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_abort_q <= 1'b0;
            s1_din_q   <= '0;
        end else begin
            s1_valid_q <= beat_accept;
            s1_first_q <= beat_first;
            s1_last_q  <= beat_last;
            s1_abort_q <= beat_abort;
            if (beat_accept) begin
                s1_din_q <= din;
            end
        end
    end

    assign err_short = s1_valid_q && s1_abort_q;

    // ------------------------------------------------------------------
    // S2: signed product
    // ------------------------------------------------------------------
    logic signed [ProdWidth-1:0] din_ext;
    logic signed [ProdWidth-1:0] coef_ext;
    logic signed [ProdWidth-1:0] prod;

    // Both operands are sign-extended to the full product width, so the low
    // ProdWidth bits of the product are the exact signed result.
    always_comb begin
        din_ext  = {{CWIDTH{s1_din_q[DWIDTH-1]}}, s1_din_q};
        coef_ext = {{DWIDTH{coef_data[CWIDTH-1]}}, coef_data};
        prod     = din_ext * coef_ext;
    end

    logic                        s2_valid_q;
    logic                        s2_first_q;
    logic                        s2_last_q;
    logic signed [ProdWidth-1:0] s2_prod_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_prod_q  <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            if (s1_valid_q) begin
                s2_prod_q <= prod;
            end
        end
    end

    // ------------------------------------------------------------------
    // S3: accumulate, then round and saturate the final sum
    // ------------------------------------------------------------------
    logic signed [ACCWIDTH-1:0] acc_q, acc_d;
    logic signed [ACCWIDTH-1:0] prod_ext;
    logic signed [ACCWIDTH:0]   rnd_half;
    logic signed [ACCWIDTH:0]   rnd_sum;
    logic signed [ACCWIDTH:0]   rnd_shift;
    logic                       rnd_ovf;
    logic        [DWIDTH-1:0]   rnd_sat;

    always_comb begin
        prod_ext = {{(ACCWIDTH - ProdWidth){s2_prod_q[ProdWidth-1]}}, s2_prod_q};
        // A first-flagged beat reloads the accumulator, so back-to-back bursts
        // and the remains of an aborted burst never leak into a new sum.
        acc_d    = s2_first_q ? prod_ext : acc_q + prod_ext;

        // One guard bit keeps the half-LSB addition from wrapping.
        rnd_half              = '0;
        rnd_half[CWIDTH-2]    = 1'b1;
        rnd_sum               = {acc_d[ACCWIDTH-1], acc_d} + rnd_half;
        rnd_shift             = rnd_sum >>> (CWIDTH - 1);

        // Representable only when every bit above the output sign bit matches it.
        rnd_ovf = !((&rnd_shift[ACCWIDTH:DWIDTH-1]) || !(|rnd_shift[ACCWIDTH:DWIDTH-1]));
        if (!rnd_ovf) begin
            rnd_sat = rnd_shift[DWIDTH-1:0];
        end else if (rnd_shift[ACCWIDTH]) begin
            rnd_sat = {1'b1, {(DWIDTH - 1){1'b0}}};
        end else begin
            rnd_sat = {1'b0, {(DWIDTH - 1){1'b1}}};
        end
    end

    logic [DWIDTH-1:0] dout_q;
    logic              dout_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            if (s2_valid_q) begin
                acc_q <= acc_d;
            end
            if (s2_valid_q && s2_last_q) begin
                dout_q       <= rnd_sat;
                dout_valid_q <= 1'b1;
            end else begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == StRun) || s1_valid_q || s2_valid_q || dout_valid_q;

endmodule
